seg7_display_arbiter: RTL and testbench
=======================================

// Module: seg7_display_arbiter
// PURPOSE
//  Shares the single 4-digit seven-segment display between NREQ producers
//  (e.g. speed, heading, last Bluetooth command). Drives the display
//  driver's 16-bit x word.
//  Each producer posts a value with a one-cycle update pulse. The arbiter
//  grants producers round-robin. Each granted value stays on the display
//  for at least HOLD_CYCLES clocks.
// PARAMETERS
//  NREQ         3           number of producers (2..4)
//  SRC_W        2           width of disp_src; must satisfy 2**SRC_W >= NREQ
//  HOLD_CYCLES  50_000_000  minimum display time per grant, in clk cycles (>=1)
//  HOLD_W       26          hold counter width; 2**HOLD_W > HOLD_CYCLES
// PORTS
//  clk       in   1         system clock
//  clr       in   1         asynchronous reset, active-high
//  upd       in   NREQ      per-producer one-cycle "new value" pulse
//  val       in   16*NREQ   packed values; producer i uses val[16*i+15:16*i]
//  ack       out  NREQ      one-cycle pulse: producer i's value was just shown
//  disp_x    out  16        4 hex nibbles to the display driver, MSB = left digit
//  disp_src  out  SRC_W     index of the producer currently shown
//  busy      out  1         1 while the hold timer runs (state HOLD)
// BEHAVIOUR
//  Reset (clr=1, async) sets all of the following:
//  - disp_x=16'h0000, disp_src=0, ack=0, busy=0
//  - pending=0, shadow regs=0, hold cnt=0, state=IDLE
//  - last=NREQ-1, so producer 0 wins first
//  Capture:
//  - Edge with upd[i]=1: shadow[i]<=val[i] and pending[i]<=1.
//  - Latest value wins. Repeated upd while pending: no extra grants.
//  FSM with 2 states, IDLE and HOLD.
//  - IDLE, pending==0: hold disp_x/disp_src, stay IDLE.
//  - IDLE, pending!=0: sel = first pending index scanning last+1, last+2, ...
//    (mod NREQ). On the same edge:
//    - disp_x<=shadow[sel], disp_src<=sel, last<=sel
//    - pending[sel]<=0, ack[sel]<=1 (one cycle)
//    - cnt<=HOLD_CYCLES-1, state<=HOLD
//  - HOLD: cnt decrements each edge. Edge with cnt==0 -> IDLE.
//    HOLD therefore lasts exactly HOLD_CYCLES cycles.
//  Timing:
//  - Latency: upd at edge N, display idle -> disp_x updates at edge N+1;
//    ack high during cycle N+1..N+2.
//  - Minimum spacing between consecutive grants: HOLD_CYCLES+1 cycles.
//  Boundary cases:
//  - upd[i] on the same edge producer i is granted: the old shadow value is
//    shown; the new value is captured and pending[i] stays 1.
//  - Pending set for a producer other than the one shown is served only
//    after the hold expires. No starvation: each producer waits at most
//    NREQ grants.
//  - clr mid-HOLD: immediate return to reset values. Pending updates are
//    discarded.
//  - ack is never asserted for more than one producer or for more than
//    one cycle per grant.
// CONFIGURATION
//  ALERT_PREEMPT_EN defined:
//  - Producer 0 is an alert source.
//  - pending[0]=1 while in HOLD with disp_src!=0 forces cnt<=0 and
//    state<=IDLE on that edge.
//  - The next IDLE edge grants producer 0 regardless of round-robin order;
//    last<=0.
//  - Producer 0 never preempts itself.
//  ALERT_PREEMPT_EN undefined:
//  - Producer 0 is an ordinary round-robin member.
//  - No hold is ever shortened.
// TESTING (bench: NREQ=3, HOLD_CYCLES=4)
//  1 Reset:
//    clr pulse mid-run -> disp_x=0000, disp_src=0, ack=000, busy=0 in the
//    same cycle. Pending is lost; no grant without a new upd.
//  2 Single update:
//    upd[1] with val1=16'h1234 at edge N
//    -> disp_x=1234, disp_src=1, ack=010 at N+1; busy high for 4 cycles.
//  3 Round robin:
//    upd=111 on one edge with vals AAAA/BBBB/CCCC
//    -> shown AAAA, BBBB, CCCC in that order; grants 5 cycles apart;
//    each ack fires exactly once.
//  4 Overwrite:
//    upd[2] with 0001, then upd[2] with 0002 during another producer's
//    hold -> only 0002 shown; a single ack[2].
//  5 Update on grant edge:
//    upd[0]=5555 on the edge producer 0 is granted 4444
//    -> 4444 shown; after the hold, 5555 shown (if no other pending).
//  6 ALERT_PREEMPT_EN:
//    producer 2 in HOLD with cnt=3, upd[0]=0E00
//    -> busy falls next edge; disp_x=0E00 one edge later.
//    Without the macro: 0E00 appears only after the hold completes.

Source files
------------

// File: rtl/seg7_display_arbiter_if.sv
// Producer/display bus of seg7_display_arbiter: update pulses and values in,
// grant acks and the shown display word out.
interface seg7_display_arbiter_if #(
    parameter int NREQ  = 3,
    parameter int SRC_W = 2
);
    logic [NREQ-1:0]      upd;
    logic [16*NREQ-1:0]   val;
    logic [NREQ-1:0]      ack;
    logic [15:0]          disp_x;
    logic [SRC_W-1:0]     disp_src;
    logic                 busy;

    modport master (
        output upd, val,
        input  ack, disp_x, disp_src, busy
    );

    modport slave (
        input  upd, val,
        output ack, disp_x, disp_src, busy
    );
endinterface

// File: rtl/seg7_display_arbiter.sv
// Round-robin sharing of one 4-digit seven-segment display between NREQ producers.
// Optional macro ALERT_PREEMPT_EN: producer 0 cuts short any other producer's hold.
module seg7_display_arbiter #(
    parameter int NREQ        = 3,
    parameter int SRC_W       = 2,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int HOLD_W      = 26
) (
    input  logic                  clk,
    input  logic                  clr,
    seg7_display_arbiter_if.slave bus
);
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [HOLD_W-1:0]  r_cnt;
    logic [HOLD_W-1:0]  w_cnt_nxt;
    logic [15:0]        r_shadow [NREQ];
    logic [NREQ-1:0]    r_pending;
    logic [NREQ-1:0]    w_pending_nxt;
    logic [SRC_W-1:0]   r_last;
    logic [SRC_W-1:0]   w_sel;
    logic [SRC_W-1:0]   w_idx;
    logic [NREQ-1:0]    w_sel_oh;
    logic               w_found;
    logic               w_grant;
    logic [15:0]        r_disp_x;
    logic [SRC_W-1:0]   r_disp_src;
    logic [NREQ-1:0]    r_ack;
    logic               r_busy;
`ifdef ALERT_PREEMPT_EN
    logic               r_alert;
    logic               w_alert_nxt;
`endif

    // Round-robin pick: first pending producer after the last one granted
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx   = SRC_W'((int'(r_last) + k) % NREQ);
            w_sel   = (!w_found && r_pending[w_idx]) ? w_idx : w_sel;
            w_found = w_found | r_pending[w_idx];
        end
`ifdef ALERT_PREEMPT_EN
        w_sel = (r_alert && r_pending[0]) ? '0 : w_sel;
`endif
        w_sel_oh = NREQ'(1) << w_sel;
    end

    // Next-state logic: grant from IDLE, count the hold down in HOLD
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
`ifdef ALERT_PREEMPT_EN
        w_alert_nxt = r_alert;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = HOLD_W'(HOLD_CYCLES - 1);
`ifdef ALERT_PREEMPT_EN
                    w_alert_nxt = 1'b0;
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
`ifdef ALERT_PREEMPT_EN
                // A waiting alert aborts another producer's hold; the next IDLE edge serves it
                if (r_pending[0] && (r_disp_src != '0)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_alert_nxt = 1'b1;
                end else
`endif
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // Clear before set, so an update on its own grant edge stays pending
        w_pending_nxt = (r_pending & ~(w_grant ? w_sel_oh : '0)) | bus.upd;
    end

    // FSM state, hold counter and request bookkeeping
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_last    <= SRC_W'(NREQ - 1);
`ifdef ALERT_PREEMPT_EN
            r_alert   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_last    <= w_grant ? w_sel : r_last;
`ifdef ALERT_PREEMPT_EN
            r_alert   <= w_alert_nxt;
`endif
        end
    end

    // Latest posted value per producer
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREQ; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.upd[i]) begin
                    r_shadow[i] <= bus.val[16*i +: 16];
                end
            end
        end
    end

    // Registered display outputs and grant acknowledge
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_disp_x   <= 16'h0000;
            r_disp_src <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_ack  <= w_grant ? w_sel_oh : '0;
            r_busy <= (w_state_nxt == S_HOLD);
            if (w_grant) begin
                r_disp_x   <= r_shadow[w_sel];
                r_disp_src <= w_sel;
            end
        end
    end

    assign bus.disp_x   = r_disp_x;
    assign bus.disp_src = r_disp_src;
    assign bus.ack      = r_ack;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Self-checking bench for seg7_display_arbiter (NREQ=3, HOLD_CYCLES=4): directed
// scenarios plus randomized traffic against a timeline reference model.
module tb_seg7_display_arbiter;
    localparam int H = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    seg7_display_arbiter_if #(.NREQ(3), .SRC_W(2)) bus ();

    seg7_display_arbiter #(
        .NREQ(3), .SRC_W(2), .HOLD_CYCLES(H), .HOLD_W(3)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: grants happen on a timeline; a hold started at edge m_g ends at m_hold_end
    logic [15:0] m_shadow [3];
    logic [2:0]  m_pending;
    int          m_last;
    logic [15:0] m_disp;
    logic [1:0]  m_src;
    logic [2:0]  m_ack;
    logic        m_busy;
    logic        m_alert;
    int          m_cyc, m_g, m_hold_end;

    task automatic m_reset();
        for (int i = 0; i < 3; i++) m_shadow[i] = 16'h0000;
        m_pending = 3'b000; m_last = 2; m_disp = 16'h0000; m_src = 2'd0;
        m_ack = 3'b000; m_busy = 1'b0; m_alert = 1'b0;
        m_cyc = 0; m_g = 0; m_hold_end = 0;
    endtask

    task automatic model_edge(input logic [2:0] u, input logic [47:0] v);
        int  sel;
        bit  in_hold;
        m_cyc++;
        m_ack   = 3'b000;
        in_hold = (m_cyc > m_g) && (m_cyc <= m_hold_end);
`ifdef ALERT_PREEMPT_EN
        if (in_hold && m_pending[0] && m_src != 2'd0) begin
            m_hold_end = m_cyc;
            m_alert    = 1'b1;
        end
`endif
        if (m_cyc > m_hold_end && m_pending != 3'b000) begin
            sel = -1;
            if (m_alert && m_pending[0]) sel = 0;
            for (int k = 1; k <= 3; k++) begin
                if (sel < 0 && m_pending[(m_last + k) % 3]) sel = (m_last + k) % 3;
            end
            m_disp = m_shadow[sel]; m_src = 2'(sel); m_last = sel;
            m_pending[sel] = 1'b0; m_ack[sel] = 1'b1;
            m_g = m_cyc; m_hold_end = m_cyc + H; m_alert = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (u[i]) begin
                m_shadow[i]  = v[16*i +: 16];
                m_pending[i] = 1'b1;
            end
        end
        m_busy = (m_cyc >= m_g) && (m_cyc < m_hold_end);
    endtask

    task automatic step(input logic [2:0] u, input logic [47:0] v);
        bus.upd = u;
        bus.val = v;
        @(posedge clk);
        model_edge(u, v);
        #1;
        bus.upd = 3'b000;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        clr = 1'b1;
        #2;
        clr = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        n_tests++; if (bus.disp_x !== 16'h0000) begin n_fail++; $display("FAIL reset_disp_x: got %h expected 0000", bus.disp_x); end
        n_tests++; if (bus.disp_src !== 2'd0) begin n_fail++; $display("FAIL reset_disp_src: got %0d expected 0", bus.disp_src); end
        n_tests++; if (bus.ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b expected 000", bus.ack); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        step(3'b010, {16'h0000, 16'h9999, 16'h0000});
        step(3'b100, {16'h2222, 16'h0000, 16'h0000});
        clr = 1'b1;
        #1;
        n_tests++; if (bus.disp_x !== 16'h0000) begin n_fail++; $display("FAIL midreset_disp_x: got %h expected 0000", bus.disp_x); end
        n_tests++; if (bus.disp_src !== 2'd0) begin n_fail++; $display("FAIL midreset_disp_src: got %0d expected 0", bus.disp_src); end
        n_tests++; if (bus.ack !== 3'b000) begin n_fail++; $display("FAIL midreset_ack: got %b expected 000", bus.ack); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
        #1;
        clr = 1'b0;
        m_reset();
        for (int c = 0; c < 12; c++) begin
            step(3'b000, 48'h0);
            n_tests++;
            if (bus.ack !== 3'b000 || bus.disp_x !== 16'h0000 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_grant: cycle %0d got ack=%b disp_x=%h busy=%b expected 000/0000/0", c, bus.ack, bus.disp_x, bus.busy);
            end
        end
    endtask

    task automatic test_single_update();
        step(3'b010, {16'h0000, 16'h1234, 16'h0000});
        n_tests++; if (bus.ack !== 3'b000) begin n_fail++; $display("FAIL single_capture_ack: got %b expected 000", bus.ack); end
        step(3'b000, 48'h0);
        n_tests++; if (bus.disp_x !== 16'h1234) begin n_fail++; $display("FAIL single_disp_x: got %h expected 1234", bus.disp_x); end
        n_tests++; if (bus.disp_src !== 2'd1) begin n_fail++; $display("FAIL single_disp_src: got %0d expected 1", bus.disp_src); end
        n_tests++; if (bus.ack !== 3'b010) begin n_fail++; $display("FAIL single_ack: got %b expected 010", bus.ack); end
        for (int c = 0; c < H; c++) begin
            if (c > 0) step(3'b000, 48'h0);
            n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_high: cycle %0d got %b expected 1", c, bus.busy); end
        end
        step(3'b000, 48'h0);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_low: got %b expected 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        int          gcyc[$];
        logic [15:0] gval[$];
        logic [2:0]  gack[$];
        int          acks[3];
        logic [15:0] exp_val[3];
        acks = '{0, 0, 0};
        exp_val = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        do_reset();
        for (int c = 0; c < 16; c++) begin
            if (c == 0) step(3'b111, {16'hCCCC, 16'hBBBB, 16'hAAAA});
            else        step(3'b000, 48'h0);
            if (bus.ack !== 3'b000) begin
                gcyc.push_back(c); gval.push_back(bus.disp_x); gack.push_back(bus.ack);
                for (int i = 0; i < 3; i++) acks[i] += int'(bus.ack[i]);
            end
        end
        n_tests++; if (gcyc.size() != 3) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 3", gcyc.size()); end
        if (gcyc.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                n_tests++; if (gval[k] !== exp_val[k]) begin n_fail++; $display("FAIL rr_order: grant %0d got %h expected %h", k, gval[k], exp_val[k]); end
                n_tests++; if (gack[k] !== 3'(1 << k)) begin n_fail++; $display("FAIL rr_ack: grant %0d got %b expected %b", k, gack[k], 3'(1 << k)); end
            end
            for (int k = 1; k < 3; k++) begin
                n_tests++; if (gcyc[k] - gcyc[k-1] != H + 1) begin n_fail++; $display("FAIL rr_spacing: got %0d expected %0d", gcyc[k] - gcyc[k-1], H + 1); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (acks[i] != 1) begin n_fail++; $display("FAIL rr_ack_once: producer %0d got %0d acks expected 1", i, acks[i]); end
        end
    endtask

    task automatic test_overwrite();
        int          n_ack2;
        logic [15:0] shown2;
        bit          saw_old;
        n_ack2 = 0; shown2 = 16'h0000; saw_old = 1'b0;
        do_reset();
        step(3'b001, {16'h0000, 16'h0000, 16'h1111});
        step(3'b100, {16'h0001, 16'h0000, 16'h0000});
        step(3'b000, 48'h0);
        step(3'b100, {16'h0002, 16'h0000, 16'h0000});
        for (int c = 0; c < 12; c++) begin
            step(3'b000, 48'h0);
            if (bus.ack[2] === 1'b1) begin n_ack2++; shown2 = bus.disp_x; end
            if (bus.disp_x === 16'h0001) saw_old = 1'b1;
        end
        n_tests++; if (n_ack2 != 1) begin n_fail++; $display("FAIL overwrite_ack_count: got %0d expected 1", n_ack2); end
        n_tests++; if (shown2 !== 16'h0002) begin n_fail++; $display("FAIL overwrite_value: got %h expected 0002", shown2); end
        n_tests++; if (saw_old) begin n_fail++; $display("FAIL overwrite_stale: got 0001 shown expected never"); end
    endtask

    task automatic test_update_on_grant();
        do_reset();
        step(3'b001, {16'h0000, 16'h0000, 16'h4444});
        step(3'b001, {16'h0000, 16'h0000, 16'h5555});
        n_tests++; if (bus.disp_x !== 16'h4444) begin n_fail++; $display("FAIL grant_edge_old: got %h expected 4444", bus.disp_x); end
        n_tests++; if (bus.ack !== 3'b001) begin n_fail++; $display("FAIL grant_edge_ack: got %b expected 001", bus.ack); end
        for (int c = 0; c < H; c++) step(3'b000, 48'h0);
        n_tests++; if (bus.disp_x !== 16'h4444) begin n_fail++; $display("FAIL grant_edge_hold: got %h expected 4444", bus.disp_x); end
        step(3'b000, 48'h0);
        n_tests++; if (bus.disp_x !== 16'h5555) begin n_fail++; $display("FAIL grant_edge_new: got %h expected 5555", bus.disp_x); end
        n_tests++; if (bus.ack !== 3'b001) begin n_fail++; $display("FAIL grant_edge_new_ack: got %b expected 001", bus.ack); end
    endtask

    task automatic test_preempt();
        do_reset();
        step(3'b100, {16'h2222, 16'h0000, 16'h0000});
        step(3'b000, 48'h0);
        n_tests++; if (bus.disp_src !== 2'd2) begin n_fail++; $display("FAIL preempt_setup_src: got %0d expected 2", bus.disp_src); end
        step(3'b001, {16'h0000, 16'h0000, 16'h0E00});
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL preempt_busy_before: got %b expected 1", bus.busy); end
`ifdef ALERT_PREEMPT_EN
        step(3'b000, 48'h0);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL preempt_busy_falls: got %b expected 0", bus.busy); end
        n_tests++; if (bus.disp_x !== 16'h2222) begin n_fail++; $display("FAIL preempt_disp_wait: got %h expected 2222", bus.disp_x); end
        step(3'b000, 48'h0);
`else
        for (int c = 0; c < 3; c++) step(3'b000, 48'h0);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL preempt_busy_falls: got %b expected 0", bus.busy); end
        n_tests++; if (bus.disp_x !== 16'h2222) begin n_fail++; $display("FAIL preempt_disp_wait: got %h expected 2222", bus.disp_x); end
        step(3'b000, 48'h0);
`endif
        n_tests++; if (bus.disp_x !== 16'h0E00) begin n_fail++; $display("FAIL preempt_disp_alert: got %h expected 0E00", bus.disp_x); end
        n_tests++; if (bus.ack !== 3'b001) begin n_fail++; $display("FAIL preempt_ack: got %b expected 001", bus.ack); end
    endtask

    task automatic test_random();
        logic [2:0]  u;
        logic [47:0] v;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) u[i] = ($urandom_range(0, 3) == 0);
            v[47:32] = 16'($urandom);
            v[31:0]  = $urandom;
            step(u, v);
            n_tests++; if (bus.disp_x !== m_disp) begin n_fail++; $display("FAIL rand_disp_x: cycle %0d got %h expected %h", c, bus.disp_x, m_disp); end
            n_tests++; if (bus.disp_src !== m_src) begin n_fail++; $display("FAIL rand_disp_src: cycle %0d got %0d expected %0d", c, bus.disp_src, m_src); end
            n_tests++; if (bus.ack !== m_ack) begin n_fail++; $display("FAIL rand_ack: cycle %0d got %b expected %b", c, bus.ack, m_ack); end
            n_tests++; if (bus.busy !== m_busy) begin n_fail++; $display("FAIL rand_busy: cycle %0d got %b expected %b", c, bus.busy, m_busy); end
            n_tests++; if ($countones(bus.ack) > 1) begin n_fail++; $display("FAIL rand_ack_onehot: cycle %0d got %b expected at most one bit", c, bus.ack); end
        end
    endtask

    initial begin
        bus.upd = 3'b000;
        bus.val = 48'h0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        m_reset();
        test_reset();
        test_single_update();
        test_round_robin();
        test_overwrite();
        test_update_on_grant();
        test_preempt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached expected completion");
        $fatal(1);
    end
endmodule
